spram_port: RTL

Initiator-side port controller for the 16-bit x 16K single-port SPRAM macro. It turns byte-addressed 8/16/32-bit CPU requests into one or more SPRAM word cycles: it drives address, nibble write masks and chip select, then gathers the registered read data. It also puts the macro into standby after a programmable idle period. It sits between the eForth core memory bus and the SPRAM instance.

---
 rtl/spram_port.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/spram_port.sv
// spram_port: splits byte-addressed 8/16/32-bit requests into 16-bit SPRAM word
// beats, gathers registered read data, and parks the macro in standby when idle.
module spram_port #(
  parameter int IDLE_SLEEP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [14:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [13:0] mem_ad,
  output logic [15:0] mem_di,
  output logic [3:0]  mem_maskwe,
  output logic        mem_we,
  output logic        mem_cs,
  output logic        mem_stdby,
  output logic        mem_sleep,
  output logic        mem_pwroff_n,
  input  logic [15:0] mem_do
);

  localparam int CW = (IDLE_SLEEP < 2) ? 1 : $clog2(IDLE_SLEEP);
  localparam logic [CW-1:0] SLEEP_LAST = CW'(IDLE_SLEEP - 1);

  typedef enum logic [2:0] {IDLE, BEAT, DRAIN, STBY, WAKE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idleCnt_q, idleCnt_d;

  logic        reqWe_q, reqOff_q;
  logic [2:0]  reqN_q;
  logic [13:0] reqWord_q;
  logic [31:0] reqData_q, acc_q;
  logic [1:0]  beats_q, beatIdx_q, lastIdx_q;
  logic        lastRd_q, rspValid_q;
  logic [31:0] rspRdata_q;
  logic [13:0] memAd_q;
  logic [15:0] memDi_q;
  logic [3:0]  memMask_q;
  logic        memWe_q, memCs_q;

  logic        accept, lastBeat;
  logic [2:0]  inN;
  logic [1:0]  inBeats;
  logic        srcWe, srcOff;
  logic [2:0]  srcN, idxLo, idxHi, rdLo, rdHi;
  logic [13:0] srcWord, beatAd;
  logic [31:0] srcData, merged;
  logic [1:0]  nextIdx;
  logic [3:0]  beatMask;
  logic [15:0] beatDi;

  // Byte count and beat count of the incoming request; an odd start adds a beat.
  always_comb begin
    inN     = 3'd4;
    inBeats = 2'd2 + {1'b0, req_addr[0]};
    case (req_size)
      2'd0: begin inN = 3'd1; inBeats = 2'd1; end
      2'd1: begin inN = 3'd2; inBeats = 2'd1 + {1'b0, req_addr[0]}; end
      default: ;
    endcase
  end

  assign lastBeat = (beatIdx_q == beats_q - 2'd1);

  // Beat 0 comes straight from the bus at acceptance; later beats from the latch.
  // A lane index below zero wraps to 7, which always fails the < N test.
  always_comb begin
    srcWe   = req_we;
    srcOff  = req_addr[0];
    srcN    = inN;
    srcWord = req_addr[14:1];
    srcData = req_wdata;
    nextIdx = 2'd0;
    if (state_q != IDLE) begin
      srcWe   = reqWe_q;
      srcOff  = reqOff_q;
      srcN    = reqN_q;
      srcWord = reqWord_q;
      srcData = reqData_q;
      nextIdx = beatIdx_q + 2'd1;
    end
    beatAd   = srcWord + {12'd0, nextIdx};
    idxLo    = {nextIdx, 1'b0} - {2'd0, srcOff};
    idxHi    = {nextIdx, 1'b1} - {2'd0, srcOff};
    beatMask = 4'b0000;
    beatDi   = 16'h0000;
    if (idxLo < srcN) begin
      beatMask[1:0] = 2'b11;
      beatDi[7:0]   = srcData[{idxLo[1:0], 3'b000} +: 8];
    end
    if (idxHi < srcN) begin
      beatMask[3:2] = 2'b11;
      beatDi[15:8]  = srcData[{idxHi[1:0], 3'b000} +: 8];
    end
    if (!srcWe) begin
      beatMask = 4'b0000;
      beatDi   = 16'h0000;
    end
  end

  // Place the lanes of the beat whose data is on mem_do now into response bytes.
  always_comb begin
    rdLo   = {lastIdx_q, 1'b0} - {2'd0, reqOff_q};
    rdHi   = {lastIdx_q, 1'b1} - {2'd0, reqOff_q};
    merged = acc_q;
    if (rdLo < reqN_q) merged[{rdLo[1:0], 3'b000} +: 8] = mem_do[7:0];
    if (rdHi < reqN_q) merged[{rdHi[1:0], 3'b000} +: 8] = mem_do[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idleCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idleCnt_q <= idleCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idleCnt_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BEAT;
        end else if (IDLE_SLEEP != 0) begin
          if (idleCnt_q == SLEEP_LAST) state_d = STBY;
          else idleCnt_d = idleCnt_q + CW'(1);
        end
      end
      BEAT:    if (lastBeat) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      STBY:    if (req_valid) state_d = WAKE;
      WAKE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_stdby = (state_q == STBY);
    accept    = (state_q == IDLE) && req_valid;
  end

  // Datapath: request latch, registered SPRAM pins, read gather and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      reqWe_q    <= 1'b0;
      reqOff_q   <= 1'b0;
      reqN_q     <= 3'd0;
      reqWord_q  <= 14'd0;
      reqData_q  <= 32'd0;
      beats_q    <= 2'd0;
      beatIdx_q  <= 2'd0;
      lastIdx_q  <= 2'd0;
      lastRd_q   <= 1'b0;
      acc_q      <= 32'd0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'd0;
      memAd_q    <= 14'd0;
      memDi_q    <= 16'd0;
      memMask_q  <= 4'd0;
      memWe_q    <= 1'b0;
      memCs_q    <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      lastRd_q   <= (state_q == BEAT) && !reqWe_q;
      lastIdx_q  <= beatIdx_q;
      if (lastRd_q) acc_q <= merged;
      if (accept) begin
        reqWe_q   <= req_we;
        reqOff_q  <= req_addr[0];
        reqN_q    <= inN;
        reqWord_q <= req_addr[14:1];
        reqData_q <= req_wdata;
        beats_q   <= inBeats;
        beatIdx_q <= 2'd0;
        acc_q     <= 32'd0;
        memAd_q   <= beatAd;
        memDi_q   <= beatDi;
        memMask_q <= beatMask;
        memWe_q   <= req_we;
        memCs_q   <= 1'b1;
      end else if (state_q == BEAT) begin
        if (lastBeat) begin
          memDi_q   <= 16'd0;
          memMask_q <= 4'd0;
          memWe_q   <= 1'b0;
          memCs_q   <= 1'b0;
        end else begin
          beatIdx_q <= nextIdx;
          memAd_q   <= beatAd;
          memDi_q   <= beatDi;
          memMask_q <= beatMask;
        end
      end
      // Writes leave rsp_rdata alone; the beef pattern on mem_do is never gathered.
      if (state_q == DRAIN) begin
        rspValid_q <= 1'b1;
        if (lastRd_q) rspRdata_q <= merged;
      end
    end
  end

  assign rsp_valid    = rspValid_q;
  assign rsp_rdata    = rspRdata_q;
  assign mem_ad       = memAd_q;
  assign mem_di       = memDi_q;
  assign mem_maskwe   = memMask_q;
  assign mem_we       = memWe_q;
  assign mem_cs       = memCs_q;
  assign mem_sleep    = 1'b0;
  assign mem_pwroff_n = 1'b1;

endmodule
